// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial unsigned subtractor: diff = (X - Y - B0) mod 2^WIDTH, one bit
//   per clock, LSB first, using one full-subtractor cell and a borrow flop.
//   A start/busy/done handshake frames each operation (IDLE -> RUN -> DONE).
//
//   Optional build macro SERIAL_SUB_ADD_MODE_EN adds port op (1 = add,
//   0 = subtract). In add mode B0 is the carry-in and borrow_out carries the
//   final carry-out.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request new operation (sampled in IDLE or DONE only)
//   X, Y       in   minuend / subtrahend, latched on the accepting edge
//   B0         in   borrow-in (carry-in in add mode), latched with operands
//   op         in   (SERIAL_SUB_ADD_MODE_EN only) 1 = add, 0 = subtract
//   busy       out  high while bits are being computed
//   done       out  one-cycle pulse when diff/borrow_out update
//   diff       out  registered result, held until the next completion
//   borrow_out out  registered final borrow (or carry), held with diff
// ---------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             B0,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             op,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_sr;
    logic             r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_bo;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic             r_op;
`endif

    logic             w_xi;
    logic             w_yi;
    logic             w_d;
    logic             w_b_nxt;
    logic             w_last;
    logic             w_accept;

    assign w_xi = r_x[0];
    assign w_yi = r_y[0];

    // Sum/difference bit is the same XOR for both modes; only the
    // borrow/carry recurrence differs.
    assign w_d = w_xi ^ w_yi ^ r_b;

`ifdef SERIAL_SUB_ADD_MODE_EN
    assign w_b_nxt = r_op ? ((w_xi & w_yi) | (w_xi & r_b) | (w_yi & r_b))
                          : ((~w_xi & w_yi) | (~(w_xi ^ w_yi) & r_b));
`else
    assign w_b_nxt = (~w_xi & w_yi) | (~(w_xi ^ w_yi) & r_b);
`endif

    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept = start && (r_state == S_IDLE || r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_sr    <= '0;
            r_b     <= 1'b0;
            r_diff  <= '0;
            r_bo    <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            r_op    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_x     <= X;
                        r_y     <= Y;
                        r_b     <= B0;
`ifdef SERIAL_SUB_ADD_MODE_EN
                        r_op    <= op;
`endif
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    // Operands shift right so bit i is always at [0]; result
                    // bits enter at the MSB so after WIDTH shifts bit 0 sits
                    // at the LSB.
                    r_x   <= r_x >> 1;
                    r_y   <= r_y >> 1;
                    r_b   <= w_b_nxt;
                    r_sr  <= {w_d, r_sr[WIDTH-1:1]};
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff  <= {w_d, r_sr[WIDTH-1:1]};
                        r_bo    <= w_b_nxt;
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign diff       = r_diff;
    assign borrow_out = r_bo;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] X;
    logic [W-1:0] Y;
    logic         B0;
`ifdef SERIAL_SUB_ADD_MODE_EN
    logic         op;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .X          (X),
        .Y          (Y),
        .B0         (B0),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .op         (op),
`endif
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge with the DUT in IDLE or DONE; returns #1 after
    // the accepting edge.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic b);
        X = x; Y = y; B0 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Counts edges until done is seen (bounded), then checks latency/result.
    task automatic wait_done(input string tag, input int lat, input logic [W-1:0] ed, input logic eb);
        int n;
        n = 0;
        while (n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done) break;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_diff"}, diff, ed);
        chk({tag, "_bo"}, borrow_out, eb);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; X = '0; Y = '0; B0 = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
        op = 1'b0;
`endif
        #2;
        // Reset held with junk on the inputs, including start.
        rst_n = 1'b0; start = 1'b1; X = 8'd5; Y = 8'd3; B0 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, 8'd0);
        chk("rst_bo", borrow_out, 1'b0);
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_nodone", done, 1'b0);
        end

        // Basic subtract
        launch(8'd10, 8'd3, 1'b0);
        chk("basic_busy", busy, 1'b1);
        wait_done("basic", 8, 8'd7, 1'b0);
        @(posedge clk); #1;
        chk("basic_donepulse", done, 1'b0);
        chk("basic_hold", diff, 8'd7);

        // Underflow / borrow-in
        launch(8'd3, 8'd10, 1'b0);
        wait_done("under", 8, 8'd249, 1'b1);
        launch(8'd0, 8'd0, 1'b1);
        wait_done("bin", 8, 8'd255, 1'b1);
        launch(8'd255, 8'd255, 1'b0);
        wait_done("equal", 8, 8'd0, 1'b0);

        // start and new operands mid-RUN are ignored
        @(posedge clk); #1;
        launch(8'd20, 8'd5, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        X = 8'd50; Y = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("midrun", 5, 8'd15, 1'b0);

        // start in the DONE cycle is accepted; diff held meanwhile
        launch(8'd9, 8'd4, 1'b0);
        chk("donestart_busy", busy, 1'b1);
        chk("donestart_hold", diff, 8'd15);
        wait_done("donestart", 8, 8'd5, 1'b0);

        // Reset in the 4th RUN cycle
        launch(8'd40, 8'd2, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_diff", diff, 8'd0);
        chk("midrst_bo", borrow_out, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_idle", done, 1'b0);
        launch(8'd100, 8'd1, 1'b0);
        wait_done("afterrst", 8, 8'd99, 1'b0);

`ifdef SERIAL_SUB_ADD_MODE_EN
        op = 1'b1;
        launch(8'd127, 8'd128, 1'b0);
        wait_done("add1", 8, 8'd255, 1'b0);
        launch(8'd128, 8'd128, 1'b0);
        wait_done("add2", 8, 8'd0, 1'b1);
        begin
            logic [W-1:0] yv;
            yv = 8'd1;
            for (int k = 0; k < 200; k++) begin
                launch(8'd1, yv, 1'b0);
                wait_done("chain", 8, yv + 8'd1, 1'b0);
                yv = diff;
            end
            chk("chain_final", diff, 8'd201);
        end
        op = 1'b0;
        launch(8'd3, 8'd10, 1'b0);
        wait_done("op0sub", 8, 8'd249, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
